// File: rtl/adrv9009_hb_dec2.sv
// Multi-channel half-band decimate-by-2 FIR for the ADRV9009 receive path: symmetric pre-add,
// round-half-up with saturation, sticky overflow and a per-sample bypass that keeps the same latency.
module adrv9009_hb_dec2 #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 19,
  parameter int NCH    = 2,
  parameter logic [((NTAPS+1)/4)*COEF_W-1:0] COEFS =
    {16'sd104, -16'sd406, 16'sd1120, -16'sd2802, 16'sd10188},
  parameter int ACC_W  = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic                  bypass,
  input  logic                  ovf_clear,
  output logic                  out_valid,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic                  ovf
);

  localparam int NPAIR   = (NTAPS + 1) / 4;
  localparam int CENTRE  = (NTAPS - 1) / 2;
  localparam int PRE_W   = DATA_W + 1;
  localparam int PROD_W  = PRE_W + COEF_W;
  localparam int CPROD_W = DATA_W + COEF_W;

  localparam logic signed [CPROD_W-1:0] CENTRE_COEF = CPROD_W'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W-1:0] ROUND_K =
    {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // COEFS is written as a concatenation, so h0 sits in the most significant slot.
  function automatic logic signed [COEF_W-1:0] evenTap(input int j);
    return COEFS[(NPAIR-1-j)*COEF_W +: COEF_W];
  endfunction

  logic signed [DATA_W-1:0]  delayLine_q  [NCH][NTAPS];
  logic signed [PRE_W-1:0]   preSum_q     [NCH][NPAIR];
  logic signed [DATA_W-1:0]  centreTap_q  [NCH];
  logic signed [PROD_W-1:0]  prod_q       [NCH][NPAIR];
  logic signed [CPROD_W-1:0] centreProd_q [NCH];
  logic signed [ACC_W-1:0]   acc_q        [NCH];
  logic signed [ACC_W-1:0]   acc_d        [NCH];
  logic signed [ACC_W-1:0]   rounded      [NCH];

  logic                  phase_q, phase_d;
  logic [3:0]            fire_q;
  logic [3:0]            byp_q;
  logic [NCH*DATA_W-1:0] raw1_q, raw2_q, raw3_q;
  logic                  outValid_q;
  logic [NCH*DATA_W-1:0] outData_q, outData_d;
  logic                  ovf_q, ovf_d;
  logic                  satAny;

  // Bypass pins the phase to 0 so filtering always resumes on an even sample.
  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = bypass ? 1'b0 : ~phase_q;
    end
  end

  // Control path: per-stage valid tags travel alongside the data, so gaps never shift latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= 1'b0;
      fire_q     <= '0;
      byp_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      fire_q     <= {fire_q[2:0], in_valid & ~bypass & phase_q};
      byp_q      <= {byp_q[2:0], in_valid & bypass};
      outValid_q <= fire_q[3] | byp_q[3];
      outData_q  <= outData_d;
      ovf_q      <= ovf_d;
    end
  end

  // Datapath: delay line, pre-add, multiply and sum stages, one register each.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw1_q <= '0;
      raw2_q <= '0;
      raw3_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NTAPS; i++) begin
          delayLine_q[c][i] <= '0;
        end
        for (int j = 0; j < NPAIR; j++) begin
          preSum_q[c][j] <= '0;
          prod_q[c][j]   <= '0;
        end
        centreTap_q[c]  <= '0;
        centreProd_q[c] <= '0;
        acc_q[c]        <= '0;
      end
    end else begin
      raw2_q <= raw1_q;
      raw3_q <= raw2_q;
      for (int c = 0; c < NCH; c++) begin
        if (in_valid) begin
          for (int i = NTAPS - 1; i > 0; i--) begin
            delayLine_q[c][i] <= delayLine_q[c][i-1];
          end
          delayLine_q[c][0] <= in_data[c*DATA_W +: DATA_W];
        end
        raw1_q[c*DATA_W +: DATA_W] <= delayLine_q[c][0];
        for (int j = 0; j < NPAIR; j++) begin
          preSum_q[c][j] <= PRE_W'(delayLine_q[c][2*j]) + PRE_W'(delayLine_q[c][NTAPS-1-2*j]);
          prod_q[c][j]   <= PROD_W'(preSum_q[c][j]) * PROD_W'(evenTap(j));
        end
        centreTap_q[c]  <= delayLine_q[c][CENTRE];
        centreProd_q[c] <= CPROD_W'(centreTap_q[c]) * CENTRE_COEF;
        acc_q[c]        <= acc_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      acc_d[c] = ACC_W'(centreProd_q[c]);
      for (int j = 0; j < NPAIR; j++) begin
        acc_d[c] = acc_d[c] + ACC_W'(prod_q[c][j]);
      end
    end
  end

  // Output stage: bypass samples skip rounding and saturation entirely.
  always_comb begin
    outData_d = outData_q;
    satAny    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      rounded[c] = (acc_q[c] + ROUND_K) >>> (COEF_W - 1);
      if (byp_q[3]) begin
        outData_d[c*DATA_W +: DATA_W] = raw3_q[c*DATA_W +: DATA_W];
      end else if (fire_q[3]) begin
        if (rounded[c] > SAT_MAX) begin
          outData_d[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
          satAny = 1'b1;
        end else if (rounded[c] < SAT_MIN) begin
          outData_d[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
          satAny = 1'b1;
        end else begin
          outData_d[c*DATA_W +: DATA_W] = rounded[c][DATA_W-1:0];
        end
      end
    end
    ovf_d = satAny | (ovf_q & ~ovf_clear);
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adrv9009_hb_dec2.sv
// Self-checking bench for adrv9009_hb_dec2: a direct-form convolution model checked every cycle,
// plus literal expectations for impulse, saturation, bypass and reset scenarios.
module tb_adrv9009_hb_dec2;

  localparam int NTAPS = 19;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        bypass = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int d0;
    int d1;
    bit sat;
  } pend_t;

  pend_t pend[$];
  int    hist0[$];
  int    hist1[$];
  int    hTap[NTAPS];
  int    coefList[5] = '{104, -406, 1120, -2802, 10188};
  int    imp0Lit[12] = '{0, 0, 0, 0, 16384, 0, 0, 0, 0, 0, 0, 0};
  int    imp1Lit[12] = '{104, -406, 1120, -2802, 10188, 10188, -2802, 1120, -406, 104, 0, 0};
  bit    phase = 1'b0;
  bit    expValid = 1'b0;
  bit    expOvf = 1'b0;
  int    expData0 = 0;
  int    expData1 = 0;
  int    obs0[$];
  int    obs1[$];
  int    obsCyc[$];
  int    md0, md1, my0, my1;
  bit    ms0, ms1, satNow;

  adrv9009_hb_dec2 dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .bypass   (bypass),
    .ovf_clear(ovf_clear),
    .out_valid(out_valid),
    .out_data (out_data),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit vld, input int d0, input int d1, input bit byp, input bit clr);
    @(negedge clk);
    in_valid  = vld;
    in_data   = {d1[15:0], d0[15:0]};
    bypass    = byp;
    ovf_clear = clr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    bypass = 1'b0;
    ovf_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clearObs();
    obs0.delete();
    obs1.delete();
    obsCyc.delete();
  endtask

  task automatic sendImpulse(input int pos, input int gap);
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, (k == pos) ? 32767 : 0, (k == pos) ? -32768 : 0, 1'b0, 1'b0);
      if (gap > 0) idle(gap);
    end
    idle(8);
  endtask

  task automatic checkSeq(input string tag, input bit odd);
    int e0, e1;
    checkOutput({tag, " count"}, obs0.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < obs0.size()) begin
        e0 = odd ? imp1Lit[i] : imp0Lit[i];
        e1 = odd ? -imp1Lit[i] : ((i == 4) ? -16384 : 0);
        checkOutput($sformatf("%s ch0[%0d]", tag, i), obs0[i], e0);
        checkOutput($sformatf("%s ch1[%0d]", tag, i), obs1[i], e1);
      end
    end
  endtask

  // y[n] = sum h[i]*x[n-i] over the full mirrored impulse response, then round and clamp.
  function automatic int filt(input bit ch, output bit sat);
    longint acc;
    longint r;
    int n;
    int x;
    acc = 0;
    n = hist0.size() - 1;
    for (int i = 0; i < NTAPS; i++) begin
      if (n - i >= 0) begin
        x = ch ? hist1[n-i] : hist0[n-i];
        acc += longint'(hTap[i]) * longint'(x);
      end
    end
    r = (acc + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (r > 64'sd32767) begin
      sat = 1'b1;
      r = 64'sd32767;
    end else if (r < -64'sd32768) begin
      sat = 1'b1;
      r = -64'sd32768;
    end
    return int'(r);
  endfunction

  // Reference model: every accepted sample either schedules an output 4 edges later or nothing.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend.delete();
      hist0.delete();
      hist1.delete();
      phase = 1'b0;
      expValid = 1'b0;
      expOvf = 1'b0;
      expData0 = 0;
      expData1 = 0;
    end else begin
      expValid = 1'b0;
      satNow = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        expValid = 1'b1;
        expData0 = pend[0].d0;
        expData1 = pend[0].d1;
        satNow = pend[0].sat;
        void'(pend.pop_front());
      end
      expOvf = satNow | (expOvf & !ovf_clear);
      if (in_valid) begin
        md0 = int'($signed(in_data[15:0]));
        md1 = int'($signed(in_data[31:16]));
        hist0.push_back(md0);
        hist1.push_back(md1);
        if (bypass) begin
          pend.push_back('{cyc + 4, md0, md1, 1'b0});
          phase = 1'b0;
        end else begin
          if (phase) begin
            my0 = filt(1'b0, ms0);
            my1 = filt(1'b1, ms1);
            pend.push_back('{cyc + 4, my0, my1, ms0 | ms1});
          end
          phase = !phase;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
      checkOutput("out_data", out_data, {expData1[15:0], expData0[15:0]});
      checkOutput("ovf", {31'd0, ovf}, {31'd0, expOvf});
      if (out_valid === 1'b1) begin
        obs0.push_back(int'($signed(out_data[15:0])));
        obs1.push_back(int'($signed(out_data[31:16])));
        obsCyc.push_back(cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < NTAPS; i++) hTap[i] = 0;
    for (int j = 0; j < 5; j++) begin
      hTap[2*j] = coefList[j];
      hTap[NTAPS-1-2*j] = coefList[j];
    end
    hTap[(NTAPS-1)/2] = 16384;

    doReset();
    $display("[TB] reset state");
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);

    $display("[TB] impulse at phase 0");
    clearObs();
    sendImpulse(0, 0);
    checkSeq("imp0", 1'b0);

    $display("[TB] impulse at phase 1");
    doReset();
    clearObs();
    sendImpulse(1, 0);
    checkSeq("imp1", 1'b1);
    if (obsCyc.size() > 1) checkOutput("imp1 spacing", obsCyc[1] - obsCyc[0], 2);

    $display("[TB] gapped impulse at phase 1");
    doReset();
    clearObs();
    sendImpulse(1, 2);
    checkSeq("gap", 1'b1);
    if (obsCyc.size() > 1) checkOutput("gap spacing", obsCyc[1] - obsCyc[0], 6);

    $display("[TB] DC saturation");
    doReset();
    clearObs();
    for (int k = 0; k < 30; k++) applyStimulus(1'b1, 32767, -32768, 1'b0, 1'b0);
    checkOutput("sat ovf set", {31'd0, ovf}, 32'd1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 32767, -32768, 1'b0, k[0]);
    checkOutput("sat ovf held", {31'd0, ovf}, 32'd1);
    if (obs0.size() > 0) begin
      checkOutput("sat ch0", obs0[obs0.size()-1], 32767);
      checkOutput("sat ch1", obs1[obs1.size()-1], -32768);
    end
    for (int k = 0; k < 30; k++) applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    idle(8);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput("sat ovf cleared", {31'd0, ovf}, 32'd0);

    $display("[TB] bypass");
    doReset();
    clearObs();
    applyStimulus(1'b1, 5, -32768, 1'b1, 1'b0);
    applyStimulus(1'b1, -7, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32767, 100, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1000, -1000, 1'b0, 1'b0);
    idle(8);
    checkOutput("byp count", obs0.size(), 5);
    if (obs0.size() >= 3) begin
      checkOutput("byp ch0[0]", obs0[0], 5);
      checkOutput("byp ch0[1]", obs0[1], -7);
      checkOutput("byp ch0[2]", obs0[2], 32767);
      checkOutput("byp ch1[0]", obs1[0], -32768);
      checkOutput("byp ch1[2]", obs1[2], 100);
      checkOutput("byp consecutive", obsCyc[2] - obsCyc[0], 2);
    end
    checkOutput("byp ovf", {31'd0, ovf}, 32'd0);

    $display("[TB] reset mid-stream");
    doReset();
    clearObs();
    applyStimulus(1'b1, 32767, -32768, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    doReset();
    idle(6);
    checkOutput("midrst dropped", obs0.size(), 0);
    clearObs();
    sendImpulse(0, 0);
    checkSeq("midrst imp0", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/adrv9009_hb_dec2.md
Name: adrv9009_hb_dec2

Overview:
- Parametrised, multi-channel half-band FIR decimator (decimate-by-2) for the ADRV9009 receive path.
- Successor to the fixed single-channel RHB2 stage. Adds:
  - sample-valid qualification and 2:1 decimation;
  - symmetric pre-add;
  - round-half-up and saturation with a sticky overflow flag;
  - per-sample bypass mode;
  - NCH parallel channels (I/Q) sharing one control path.

Parameters:
- DATA_W, 16, input/output sample width (signed two's complement).
- COEF_W, 16, coefficient width, Q1.(COEF_W-1) format.
- NTAPS, 19, filter length; must satisfy NTAPS = 4k+3.
- NCH, 2, number of channels processed in lock-step.
- COEFS, {16'sd104,-16'sd406,16'sd1120,-16'sd2802,16'sd10188}, packed unique even-index taps h0,h2,…,h((NTAPS-3)/2), (NTAPS+1)/4 entries × COEF_W.
  - Centre tap is fixed at 2^(COEF_W-2), i.e. 0.5.
  - Odd taps other than the centre are zero.
  - Taps are mirrored so that h[NTAPS-1-i] = h[i].
- ACC_W, 40, accumulator width; must be ≥ DATA_W+COEF_W+ceil(log2(NTAPS)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample strobe; no backpressure
- in_data  in  NCH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- bypass  in  1  1 = pass samples through undecimated and unfiltered
- ovf_clear  in  1  clears sticky overflow flag
- out_valid  out  1  output sample strobe
- out_data  out  NCH*DATA_W  filtered/decimated samples, same packing as in_data
- ovf  out  1  sticky: saturation occurred on any channel

Behaviour:
- Reset: clears the delay line, phase, pipeline valids and data. out_valid=0, out_data=0, ovf=0. Reset asserted mid-stream discards all in-flight samples; the first sample after reset is phase 0.
- Delay line: NTAPS-deep per channel. Shifts only on in_valid=1; idle cycles hold state.
- Phase bit: toggles on every accepted sample when bypass=0. It is held at 0 while bypass=1, so after leaving bypass the first sample is phase 0.
- Decimation: an output is computed for each accepted sample taken while phase=1, i.e. for input indices 1, 3, 5, … counted from reset.
- Arithmetic, per channel:
  - pre-add symmetric pairs (DATA_W+1 bits);
  - multiply by the even taps; the centre tap is multiplied separately;
  - sum into ACC_W bits;
  - add 2^(COEF_W-2) and arithmetic-shift right by COEF_W-1, giving round-half-up;
  - saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bypass: every accepted sample produces out_data = in_data with the same latency. No rounding and no saturation are applied.
- Latency: fixed at 4 clocks. If the triggering sample is accepted at edge N, out_valid=1 with data in the cycle after edge N+4 (pipeline: pre-add, multiply, sum, round/sat register).
- out_valid is a 1-cycle pulse per output. out_data holds its value between pulses.
- The pipeline advances every clock, with valid tagging. Gapped in_valid therefore never changes latency or drops outputs. Back-to-back in_valid gives one output every 2 clocks.
- ovf: set on any saturation in any channel. ovf_clear clears it. If a saturation and ovf_clear occur in the same cycle, the set wins.
- A bypass change is sampled together with in_valid. Samples already in flight complete in the mode in which they were accepted.

Test Plan:
- Impulse at phase 0: x[0]=32767, then zeros, bypass=0 → outputs 0,0,0,0,16384,0,… The 5th output is the centre tap; each output arrives 4 clocks after its odd-index input.
- Impulse at phase 1: x[0]=0, x[1]=32767, then zeros → 10 outputs of exactly 104,-406,1120,-2802,10188,10188,-2802,1120,-406,104, then 0.
- DC saturation: constant 32767 on ch0 and -32768 on ch1 → steady state 32767 / -32768; ovf=1 and stays 1. Pulsing ovf_clear during continued saturation keeps ovf=1. Clearing after zero input gives ovf=0.
- Gapped input: same stimulus as the phase-1 impulse test with in_valid duty 1/3 → identical output values. Each out_valid arrives exactly 4 clocks after its odd-index accepted sample.
- Bypass: bypass=1, samples 5,-7,32767 back-to-back → out_valid on 3 consecutive cycles with values 5,-7,32767, 4 clocks later, and ovf stays 0.
- Reset mid-stream: assert reset 2 clocks after an accepted odd sample → no out_valid for that sample. The next stream restarts at phase 0, and repeating the phase-0 impulse test reproduces its output.
